alu_sequencer: RTL and testbench

Multi-cycle initiator for the 16-bit combinational ALU. Accepts operation requests over a valid/ready handshake, drives the ALU's operand/function inputs over one or more cycles, and returns the registered result over a second valid/ready handshake. Builds barrel-style shifts (shift by N) and a 16x16 multiply out of the ALU's single-step ops, so the ALU datapath stays unchanged.

---
 rtl/alu_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Multi-cycle initiator for the 16-bit combinational ALU. Takes one
//   operation request over a valid/ready handshake, drives the ALU for
//   one or more cycles and returns a registered result over a second
//   valid/ready handshake. Shift-by-N and 16x16 multiply are built out
//   of the ALU's single-step ops, so the ALU itself stays unchanged.
//
//   Optional feature macro: ALU_SEQUENCER_MUL_EN
//     defined     : req_kind=11 runs a shift-and-add multiply (32 RUN cycles)
//     not defined : req_kind=11 finishes at once with data=0, ovf=1, zero=1
//
//   Ports
//     clk, reset_n                 clock, synchronous active-low reset
//     req_valid/req_ready          request handshake (ready only in IDLE)
//     req_kind                     00 SINGLE, 01 SHLN, 10 SHRN, 11 MUL
//     req_func                     ALU func code for SINGLE
//     req_a, req_b                 operands (req_b[3:0] = shift count)
//     rsp_valid/rsp_ready          response handshake
//     rsp_data, rsp_ovf, rsp_zero  registered result and flags
//     alu_a, alu_b, alu_func       ALU operand/function drive
//     alu_branch_type              constant BRANCH_EQ
//     alu_c, alu_ovf, alu_bcond    ALU result, overflow, zero detect
`timescale 1ns/1ps
module alu_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_kind,
  input  logic [2:0]       req_func,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ovf,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_func,
  output logic [1:0]       alu_branch_type,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_ovf,
  input  logic             alu_bcond
);

  localparam logic [1:0] KIND_SINGLE = 2'b00;
  localparam logic [1:0] KIND_SHLN   = 2'b01;
  localparam logic [1:0] KIND_SHRN   = 2'b10;
  localparam logic [1:0] KIND_MUL    = 2'b11;

  localparam logic [2:0] FUNC_ADD = 3'b000;
  localparam logic [2:0] FUNC_SHL = 3'b110;
  localparam logic [2:0] FUNC_SHR = 3'b111;

  localparam logic [1:0] BRANCH_EQ = 2'b00;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       kind_reg, kind_next;
  logic [2:0]       func_reg, func_next;
  logic [WIDTH-1:0] acc_reg, acc_next;    // operand A / shift value / product
  logic [WIDTH-1:0] opb_reg, opb_next;    // operand B for SINGLE
  logic [4:0]       cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;    // sticky partial-sum overflow
  logic [WIDTH-1:0] rsp_data_reg, rsp_data_next;
  logic             rsp_ovf_reg, rsp_ovf_next;
  logic             rsp_zero_reg, rsp_zero_next;
`ifdef ALU_SEQUENCER_MUL_EN
  localparam logic PH_ADD = 1'b0;
  localparam logic PH_SHL = 1'b1;
  logic [WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic             phase_reg, phase_next;
`endif

  assign alu_branch_type = BRANCH_EQ;
  assign rsp_data        = rsp_data_reg;
  assign rsp_ovf         = rsp_ovf_reg;
  assign rsp_zero        = rsp_zero_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      kind_reg     <= KIND_SINGLE;
      func_reg     <= FUNC_ADD;
      acc_reg      <= '0;
      opb_reg      <= '0;
      cnt_reg      <= '0;
      ovf_reg      <= 1'b0;
      rsp_data_reg <= '0;
      rsp_ovf_reg  <= 1'b0;
      rsp_zero_reg <= 1'b0;
`ifdef ALU_SEQUENCER_MUL_EN
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      phase_reg    <= PH_ADD;
`endif
    end else begin
      state_reg    <= state_next;
      kind_reg     <= kind_next;
      func_reg     <= func_next;
      acc_reg      <= acc_next;
      opb_reg      <= opb_next;
      cnt_reg      <= cnt_next;
      ovf_reg      <= ovf_next;
      rsp_data_reg <= rsp_data_next;
      rsp_ovf_reg  <= rsp_ovf_next;
      rsp_zero_reg <= rsp_zero_next;
`ifdef ALU_SEQUENCER_MUL_EN
      mcand_reg    <= mcand_next;
      mplier_reg   <= mplier_next;
      phase_reg    <= phase_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    kind_next     = kind_reg;
    func_next     = func_reg;
    acc_next      = acc_reg;
    opb_next      = opb_reg;
    cnt_next      = cnt_reg;
    ovf_next      = ovf_reg;
    rsp_data_next = rsp_data_reg;
    rsp_ovf_next  = rsp_ovf_reg;
    rsp_zero_next = rsp_zero_reg;
`ifdef ALU_SEQUENCER_MUL_EN
    mcand_next    = mcand_reg;
    mplier_next   = mplier_reg;
    phase_next    = phase_reg;
`endif
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_func  = FUNC_ADD;

    case (state_reg)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          kind_next  = req_kind;
          func_next  = req_func;
          acc_next   = req_a;
          opb_next   = req_b;
          ovf_next   = 1'b0;
          cnt_next   = {1'b0, req_b[3:0]};
          state_next = S_RUN;
          case (req_kind)
            KIND_SHLN, KIND_SHRN: begin
              // Zero-length shift: the result is the input, no ALU pass needed.
              if (req_b[3:0] == 4'd0) begin
                state_next    = S_DONE;
                rsp_data_next = req_a;
                rsp_ovf_next  = 1'b0;
                rsp_zero_next = (req_a == '0);
              end
            end
            KIND_MUL: begin
`ifdef ALU_SEQUENCER_MUL_EN
              acc_next    = '0;
              mcand_next  = req_a;
              mplier_next = req_b;
              cnt_next    = 5'd16;
              phase_next  = PH_ADD;
`else
              state_next    = S_DONE;
              rsp_data_next = '0;
              rsp_ovf_next  = 1'b1;
              rsp_zero_next = 1'b1;
`endif
            end
            default: ;
          endcase
        end
      end

      S_RUN: begin
        case (kind_reg)
          KIND_SINGLE: begin
            alu_a         = acc_reg;
            alu_b         = opb_reg;
            alu_func      = func_reg;
            rsp_data_next = alu_c;
            rsp_ovf_next  = alu_ovf;
            rsp_zero_next = alu_bcond;
            state_next    = S_DONE;
          end
          KIND_SHLN, KIND_SHRN: begin
            alu_a    = acc_reg;
            alu_func = (kind_reg == KIND_SHLN) ? FUNC_SHL : FUNC_SHR;
            acc_next = alu_c;
            cnt_next = cnt_reg - 5'd1;
            if (cnt_reg == 5'd1) begin
              rsp_data_next = alu_c;
              rsp_ovf_next  = 1'b0;
              rsp_zero_next = alu_bcond;
              state_next    = S_DONE;
            end
          end
          default: begin
`ifdef ALU_SEQUENCER_MUL_EN
            // Shift-and-add: ADD folds in the current multiplicand when the
            // multiplier LSB is set, SHL doubles the multiplicand.
            if (phase_reg == PH_ADD) begin
              alu_a      = acc_reg;
              alu_b      = mplier_reg[0] ? mcand_reg : '0;
              alu_func   = FUNC_ADD;
              acc_next   = alu_c;
              ovf_next   = ovf_reg | alu_ovf;
              phase_next = PH_SHL;
            end else begin
              alu_a       = mcand_reg;
              alu_func    = FUNC_SHL;
              mcand_next  = alu_c;
              mplier_next = mplier_reg >> 1;
              cnt_next    = cnt_reg - 5'd1;
              phase_next  = PH_ADD;
              if (cnt_reg == 5'd1) begin
                rsp_data_next = acc_reg;
                rsp_ovf_next  = ovf_reg;
                rsp_zero_next = (acc_reg == '0);
                state_next    = S_DONE;
              end
            end
`else
            // MUL never enters RUN in this build.
            state_next = S_IDLE;
`endif
          end
        endcase
      end

      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [2:0]  req_func;
  logic [15:0] req_a, req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_ovf, rsp_zero;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [2:0]  alu_func;
  logic [1:0]  alu_branch_type;
  logic        alu_ovf, alu_bcond;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_func(req_func), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_branch_type(alu_branch_type),
    .alu_c(alu_c), .alu_ovf(alu_ovf), .alu_bcond(alu_bcond)
  );

  // Behavioural model of the 16-bit combinational ALU.
  always_comb begin
    alu_c   = '0;
    alu_ovf = 1'b0;
    case (alu_func)
      3'b000: begin
        alu_c   = alu_a + alu_b;
        alu_ovf = (alu_a[15] == alu_b[15]) && (alu_c[15] != alu_a[15]);
      end
      3'b001: begin
        alu_c   = alu_a - alu_b;
        alu_ovf = (alu_a[15] != alu_b[15]) && (alu_c[15] != alu_a[15]);
      end
      3'b010: alu_c = alu_a & alu_b;
      3'b011: alu_c = alu_a | alu_b;
      3'b100: alu_c = ~alu_a;
      3'b101: alu_c = (~alu_a) + 16'd1;
      3'b110: alu_c = {alu_a[14:0], 1'b0};
      default: alu_c = {alu_a[15], alu_a[15:1]};
    endcase
    alu_bcond = (alu_c == 16'h0000);
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One request/response transaction. exp_k is the number of edges after
  // the accepting edge until rsp_valid is seen (rsp_valid is then sampled
  // high at edge T+1+k). hold = cycles of response backpressure.
  task automatic run_op(input string tag, input logic [1:0] kind, input logic [2:0] func,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_d, input logic exp_o, input logic exp_z,
                        input int exp_k, input int hold);
    int lat;
    @(negedge clk);
    check_value({tag, ".req_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_kind  = kind;
    req_func  = func;
    req_a     = a;
    req_b     = b;
    rsp_ready = (hold == 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check_value({tag, ".rsp_valid"}, rsp_valid, 1);
    check_value({tag, ".latency"}, lat, exp_k);
    check_value({tag, ".data"}, rsp_data, exp_d);
    check_value({tag, ".ovf"}, rsp_ovf, exp_o);
    check_value({tag, ".zero"}, rsp_zero, exp_z);
    check_value({tag, ".busy"}, req_ready, 0);
    for (int i = 0; i < hold; i++) begin
      // A competing request during DONE must be ignored.
      req_valid = 1'b1;
      req_kind  = 2'b00;
      req_func  = 3'b000;
      req_a     = 16'hFFFF;
      req_b     = 16'h0001;
      @(negedge clk);
      check_value({tag, ".hold_valid"}, rsp_valid, 1);
      check_value({tag, ".hold_data"}, rsp_data, exp_d);
      check_value({tag, ".hold_busy"}, req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check_value({tag, ".idle_ready"}, req_ready, 1);
    check_value({tag, ".idle_valid"}, rsp_valid, 0);
    $display("txn %s: a=%h b=%h -> data=%h ovf=%b zero=%b lat=%0d",
             tag, a, b, rsp_data, rsp_ovf, rsp_zero, lat);
  endtask

  initial begin
    int seen;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_kind  = 2'b00;
    req_func  = 3'b000;
    req_a     = 16'h0000;
    req_b     = 16'h0000;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("reset.req_ready", req_ready, 1);
    check_value("reset.rsp_valid", rsp_valid, 0);
    check_value("reset.rsp_data", rsp_data, 0);
    check_value("reset.rsp_ovf", rsp_ovf, 0);
    check_value("reset.rsp_zero", rsp_zero, 0);
    check_value("reset.alu_a", alu_a, 0);
    check_value("reset.alu_b", alu_b, 0);
    check_value("reset.alu_func", alu_func, 0);
    check_value("reset.branch", alu_branch_type, 0);
    reset_n = 1'b1;

    run_op("add_ovf",  2'b00, 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 1, 0);
    run_op("sub_zero", 2'b00, 3'b001, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1, 0);
    run_op("orr",      2'b00, 3'b011, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 1'b0, 1, 0);
    run_op("not",      2'b00, 3'b100, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0, 1, 0);
    run_op("shr1",     2'b00, 3'b111, 16'h8000, 16'h0000, 16'hC000, 1'b0, 1'b0, 1, 0);
    run_op("shln4",    2'b01, 3'b000, 16'h0003, 16'h0004, 16'h0030, 1'b0, 1'b0, 4, 0);
    run_op("shrn15",   2'b10, 3'b000, 16'h8000, 16'h000F, 16'hFFFF, 1'b0, 1'b0, 15, 0);
    run_op("shln0",    2'b01, 3'b000, 16'hABCD, 16'h0010, 16'hABCD, 1'b0, 1'b0, 0, 0);
    run_op("shrn0z",   2'b10, 3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 0, 0);
    run_op("shln1",    2'b01, 3'b000, 16'h8001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1, 0);
`ifdef ALU_SEQUENCER_MUL_EN
    run_op("mul7x9",   2'b11, 3'b000, 16'h0007, 16'h0009, 16'h003F, 1'b0, 1'b0, 32, 0);
    run_op("mulneg",   2'b11, 3'b000, 16'hFFFF, 16'h0002, 16'hFFFE, 1'b0, 1'b0, 32, 0);
    run_op("mulwrap",  2'b11, 3'b000, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b1, 32, 0);
`else
    run_op("mul_off",  2'b11, 3'b000, 16'h0007, 16'h0009, 16'h0000, 1'b1, 1'b1, 0, 0);
`endif
    run_op("backpr",   2'b00, 3'b011, 16'h0A00, 16'h00B0, 16'h0AB0, 1'b0, 1'b0, 1, 3);

    // Reset in the middle of a long shift: the operation is dropped.
    @(negedge clk);
    req_valid = 1'b1;
    req_kind  = 2'b10;
    req_a     = 16'h8000;
    req_b     = 16'h000F;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_value("midreset.req_ready", req_ready, 1);
    check_value("midreset.rsp_valid", rsp_valid, 0);
    check_value("midreset.rsp_data", rsp_data, 0);
    check_value("midreset.rsp_ovf", rsp_ovf, 0);
    check_value("midreset.rsp_zero", rsp_zero, 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check_value("midreset.no_rsp", seen, 0);
    $display("txn midreset: shrn dropped, responses seen=%0d", seen);

    run_op("and_post", 2'b00, 3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
